// File: rtl/pwm_multi_ch.sv
// N-channel complementary PWM with dead time, edge/centre carrier, double-buffered duty and
// retriggerable current-sense blanking. Define PWM_FAULT_EN to add the active-low fault_n shutdown input.
module pwm_multi_ch #(
    parameter int WIDTH       = 11,
    parameter int NUM_CH      = 3,
    parameter int DEADTIME    = 64,
    parameter int BLANK_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    center_mode,
    input  logic [NUM_CH*WIDTH-1:0] duty,
    input  logic                    duty_vld,
`ifdef PWM_FAULT_EN
    input  logic                    fault_n,
`endif
    output logic                    duty_ack,
    output logic [NUM_CH-1:0]       pwm_hi,
    output logic [NUM_CH-1:0]       pwm_lo,
    output logic                    pwm_synch,
    output logic                    ovr_I_blank
);

    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [WIDTH:0]   DT_W  = (WIDTH+1)'(DEADTIME);
    localparam logic [WIDTH-1:0] CLAMP = MAX - WIDTH'(DEADTIME);
    localparam int               BW    = $clog2(BLANK_WIDTH + 1);
    localparam logic [BW-1:0]    BLANK = BW'(BLANK_WIDTH);

    logic [WIDTH-1:0]             cnt_q, cnt_d;
    logic                         dir_up_q, dir_up_d;
    logic                         mode_q, mode_d;
    logic [NUM_CH-1:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0][WIDTH-1:0] active_q, active_d;
    logic                         pending_q, pending_d;
    logic [NUM_CH-1:0]            hi_q, hi_d;
    logic [NUM_CH-1:0]            lo_q, lo_d;
    logic [BW-1:0]                blank_q, blank_d;
    logic                         boundary;
    logic                         kill;

    // The period boundary is the up-counting zero; in centre mode that is the valley.
    assign boundary  = en && (cnt_q == '0);
    assign pwm_synch = en && (cnt_q == '0) && dir_up_q;
    assign duty_ack  = boundary && pending_q;

    always_comb begin
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        if (!en) begin
            cnt_d    = '0;
            dir_up_d = 1'b1;
        end else if (!mode_q) begin
            cnt_d    = cnt_q + 1'b1;
            dir_up_d = 1'b1;
        end else if (dir_up_q) begin
            if (cnt_q == MAX) begin
                cnt_d    = MAX - 1'b1;
                dir_up_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == WIDTH'(1)) begin
                cnt_d    = '0;
                dir_up_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Captured duty is clamped so the low side always keeps at least one dead-time gap.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        mode_d    = boundary ? center_mode : mode_q;
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (duty_vld) begin
            pending_d = 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (duty[k*WIDTH +: WIDTH] > CLAMP) shadow_d[k] = CLAMP;
                else                                shadow_d[k] = duty[k*WIDTH +: WIDTH];
            end
        end
    end

    // Hi and lo windows are disjoint by construction, so the registered pair never overlaps.
    always_comb begin
        logic [WIDTH:0] cnt_w;
        logic [WIDTH:0] d_w;
        hi_d  = '0;
        lo_d  = '0;
        cnt_w = {1'b0, cnt_q};
        d_w   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            d_w = {1'b0, active_q[k]};
            if (mode_q) begin
                hi_d[k] = en && ((cnt_w + DT_W) < d_w);
                lo_d[k] = en && (cnt_w >= d_w);
            end else begin
                hi_d[k] = en && (cnt_w >= DT_W) && (cnt_w < d_w);
                lo_d[k] = en && (cnt_w >= (d_w + DT_W)) && (cnt_q != MAX);
            end
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (|((hi_d & ~hi_q) | (lo_d & ~lo_q))) blank_d = BLANK;
        else if (blank_q != '0)                 blank_d = blank_q - 1'b1;
    end

    assign ovr_I_blank = (blank_q != '0);

`ifdef PWM_FAULT_EN
    logic fault_q, fault_d;

    // Sticky until a boundary sees the fault input released.
    always_comb begin
        fault_d = fault_q;
        if (!fault_n)      fault_d = 1'b1;
        else if (boundary) fault_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign kill = fault_q || !fault_n;
`else
    assign kill = 1'b0;
`endif

    assign pwm_hi = hi_q & ~{NUM_CH{kill}};
    assign pwm_lo = lo_q & ~{NUM_CH{kill}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            dir_up_q  <= 1'b1;
            mode_q    <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            blank_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
            mode_q    <= mode_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            blank_q   <= blank_d;
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: table of per-period pulse widths plus hand-written
// sequences for duty handshake timing, blanking, enable, fault and asynchronous reset.
module tb_pwm_multi_ch;

    localparam int WIDTH  = 11;
    localparam int NUM_CH = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic                    center_mode;
    logic [NUM_CH*WIDTH-1:0] duty;
    logic                    duty_vld;
    logic                    duty_ack;
    logic [NUM_CH-1:0]       pwm_hi;
    logic [NUM_CH-1:0]       pwm_lo;
    logic                    pwm_synch;
    logic                    ovr_I_blank;
`ifdef PWM_FAULT_EN
    logic                    fault_n = 1'b1;
`endif

    pwm_multi_ch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .center_mode (center_mode),
        .duty        (duty),
        .duty_vld    (duty_vld),
`ifdef PWM_FAULT_EN
        .fault_n     (fault_n),
`endif
        .duty_ack    (duty_ack),
        .pwm_hi      (pwm_hi),
        .pwm_lo      (pwm_lo),
        .pwm_synch   (pwm_synch),
        .ovr_I_blank (ovr_I_blank)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            mode;
        logic [2:0][11:0] d;
        logic [2:0][11:0] hi;
        logic [2:0][11:0] lo;
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_errors = 0;

    int hi_cnt[NUM_CH];
    int lo_cnt[NUM_CH];
    int ovl_cnt, syn_cnt, ack_cnt, ack_syn, blank_cnt, max_run;
    logic last_synch;

    function automatic vec_t mk(logic m, int d0, int d1, int d2,
                                int h0, int h1, int h2, int l0, int l1, int l2);
        vec_t v;
        v.mode = m;
        v.d    = {12'(d2), 12'(d1), 12'(d0)};
        v.hi   = {12'(h2), 12'(h1), 12'(h0)};
        v.lo   = {12'(l2), 12'(l1), 12'(l0)};
        return v;
    endfunction

    function automatic logic [NUM_CH*WIDTH-1:0] pack3(int d0, int d1, int d2);
        return {11'(d2), 11'(d1), 11'(d0)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic m, input logic [NUM_CH*WIDTH-1:0] dv);
        @(negedge clk);
        center_mode = m;
        duty        = dv;
        duty_vld    = 1'b1;
        @(negedge clk);
        duty_vld    = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output bit seen);
        int n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (duty_ack) seen = 1'b1;
        end
    endtask

    task automatic wait_synch(input int budget, output int waited);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            if (pwm_synch) hit = 1'b1;
        end
        waited = hit ? n : -1;
    endtask

    // Samples p consecutive negedges; optionally pulses duty_vld after sample vld_at.
    task automatic measure(input int p, input int vld_at, input logic [NUM_CH*WIDTH-1:0] vd);
        int run = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            hi_cnt[k] = 0;
            lo_cnt[k] = 0;
        end
        ovl_cnt = 0; syn_cnt = 0; ack_cnt = 0; ack_syn = 0; blank_cnt = 0; max_run = 0;
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_CH; k++) begin
                hi_cnt[k] += int'(pwm_hi[k]);
                lo_cnt[k] += int'(pwm_lo[k]);
            end
            if ((pwm_hi & pwm_lo) != '0) ovl_cnt++;
            if (pwm_synch) syn_cnt++;
            if (duty_ack) ack_cnt++;
            if (duty_ack && pwm_synch) ack_syn++;
            if (ovr_I_blank) begin
                blank_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            last_synch = pwm_synch;
            if (i == vld_at) begin
                duty     = vd;
                duty_vld = 1'b1;
            end else begin
                duty_vld = 1'b0;
            end
        end
    endtask

    initial begin
        bit seen;
        int w;
        int act;

        vecs[0] = mk(1'b0, 1024,   0, 2047,  960,   0, 1919,  959, 1983,    0);
        vecs[1] = mk(1'b1,  512, 100, 1500,  895,  71, 2871, 3071, 3895, 1095);
        vecs[2] = mk(1'b1,    0,  64, 2047,    0,   0, 3837, 4094, 3967,  129);
        vecs[3] = mk(1'b0,   64,  65,  500,    0,   1,  436, 1919, 1918, 1483);

        rst_n = 1'b0; en = 1'b0; center_mode = 1'b0; duty = '0; duty_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("rst pwm_hi", int'(pwm_hi), 0);
        check("rst pwm_lo", int'(pwm_lo), 0);
        check("rst synch", int'(pwm_synch), 0);
        check("rst ack", int'(duty_ack), 0);
        check("rst blank", int'(ovr_I_blank), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("dis pwm_hi|lo", int'(pwm_hi | pwm_lo), 0);
        check("dis synch", int'(pwm_synch), 0);
        en = 1'b1;

        for (int v = 0; v < 4; v++) begin
            int p;
            p = vecs[v].mode ? 4094 : 2048;
            load(vecs[v].mode, pack3(int'(vecs[v].d[0]), int'(vecs[v].d[1]), int'(vecs[v].d[2])));
            wait_ack(5000, seen);
            check($sformatf("v%0d ack", v), int'(seen), 1);
            wait_synch(5000, w);
            check($sformatf("v%0d synch_wait", v), w, p);
            measure(p, -1, '0);
            check($sformatf("v%0d synch_cnt", v), syn_cnt, 1);
            check($sformatf("v%0d synch_last", v), int'(last_synch), 1);
            check($sformatf("v%0d overlap", v), ovl_cnt, 0);
            for (int k = 0; k < NUM_CH; k++) begin
                check($sformatf("v%0d hi%0d", v, k), hi_cnt[k], int'(vecs[v].hi[k]));
                check($sformatf("v%0d lo%0d", v, k), lo_cnt[k], int'(vecs[v].lo[k]));
            end
        end

        // Mid-period update waits for the boundary.
        load(1'b0, pack3(1024, 1024, 1024));
        wait_ack(5000, seen);
        wait_synch(5000, w);
        check("mid synch_wait", w, 2048);
        measure(2048, 600, pack3(2047, 2047, 2047));
        check("mid hi0 old", hi_cnt[0], 960);
        check("mid lo0 old", lo_cnt[0], 959);
        check("mid ack_cnt", ack_cnt, 1);
        check("mid ack_at_boundary", ack_syn, 1);
        measure(2048, -1, '0);
        check("mid hi0 new", hi_cnt[0], 1919);
        check("mid lo0 new", lo_cnt[0], 0);
        check("mid lo1 new", lo_cnt[1], 0);
        check("mid ack_none", ack_cnt, 0);

        // duty_vld on the boundary cycle itself is applied one period later.
        check("bnd synch_now", int'(pwm_synch), 1);
        check("bnd ack_now", int'(duty_ack), 0);
        duty     = '0;
        duty_vld = 1'b1;
        measure(2048, -1, '0);
        check("bnd hi0 old", hi_cnt[0], 1919);
        check("bnd ack_cnt", ack_cnt, 1);
        check("bnd ack_at_boundary", ack_syn, 1);
        measure(2048, -1, '0);
        check("bnd hi0 zero", hi_cnt[0], 0);
        check("bnd hi2 zero", hi_cnt[2], 0);
        check("bnd lo0", lo_cnt[0], 1983);

        // Two low-side rises 50 cycles apart.
        load(1'b0, pack3(1000, 1050, 1000));
        wait_ack(5000, seen);
        check("blk ack", int'(seen), 1);
        wait_synch(5000, w);
        measure(2048, -1, '0);
        check("blk total", blank_cnt, 128 + 178);
        check("blk run", max_run, 178);
        check("blk overlap", ovl_cnt, 0);

        // Enable drop mid-period.
        repeat (500) @(negedge clk);
        check("en hi0 before", int'(pwm_hi[0]), 1);
        en = 1'b0;
        @(negedge clk);
        check("en off hi", int'(pwm_hi), 0);
        check("en off lo", int'(pwm_lo), 0);
        check("en off synch", int'(pwm_synch), 0);
        repeat (10) @(negedge clk);
        check("en off hold", int'(pwm_hi | pwm_lo), 0);
        en = 1'b1;
        wait_synch(5000, w);
        check("en restart", w, 2048);

`ifdef PWM_FAULT_EN
        repeat (300) @(negedge clk);
        check("flt hi0 before", int'(pwm_hi[0]), 1);
        fault_n = 1'b0;
        #1;
        check("flt same_cycle hi", int'(pwm_hi), 0);
        check("flt same_cycle lo", int'(pwm_lo), 0);
        @(negedge clk);
        fault_n = 1'b1;
        act = 0;
        w   = 0;
        while (!pwm_synch && w < 5000) begin
            @(negedge clk);
            w++;
            if ((pwm_hi | pwm_lo) != '0) act++;
        end
        check("flt sticky", act, 0);
        check("flt boundary", int'(pwm_synch), 1);
        measure(2048, -1, '0);
        check("flt resume hi0", hi_cnt[0], 936);
        check("flt resume lo0", lo_cnt[0], 983);
`endif

        // Asynchronous reset mid-period, inside a blanking window.
        repeat (100) @(negedge clk);
        check("ar blank before", int'(ovr_I_blank), 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar hi", int'(pwm_hi), 0);
        check("ar lo", int'(pwm_lo), 0);
        check("ar blank", int'(ovr_I_blank), 0);
        check("ar ack", int'(duty_ack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_synch(5000, w);
        check("ar synch_wait", w, 2048);
        measure(2048, -1, '0);
        check("ar hi0", hi_cnt[0], 0);
        check("ar lo0", lo_cnt[0], 1983);
        check("ar lo2", lo_cnt[2], 1983);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
N-channel complementary PWM generator for the motor drive path. It generalises the 11-bit single-channel generator with the following additions:
- parametrised counter width and channel count
- parametrised dead time
- edge-aligned or centre-aligned carrier
- glitch-free double-buffered duty update with a valid/ack handshake
- retriggerable current-sense blanking window

It sits between the commutation/control logic and the gate drivers.

Parameters:
WIDTH, 11, counter and duty width; MAX = 2^WIDTH-1
NUM_CH, 3, number of complementary channel pairs
DEADTIME, 64, non-overlap in counts; must be < MAX/2
BLANK_WIDTH, 128, blanking length in clk cycles; must be >= 1

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  generator enable
center_mode  input  1  0 = edge-aligned, 1 = centre-aligned; sampled at period boundary
duty  input  NUM_CH*WIDTH  channel k duty in bits [k*WIDTH +: WIDTH]
duty_vld  input  1  capture duty into shadow register
duty_ack  output  1  1-cycle pulse: shadow moved to active
pwm_hi  output  NUM_CH  high-side gate drives
pwm_lo  output  NUM_CH  low-side gate drives
pwm_synch  output  1  1-cycle pulse at period start
ovr_I_blank  output  1  overcurrent comparator blanking

Behaviour:
- Reset: all outputs 0; cnt=0; dir=up; shadow/active duty=0; active mode=edge; pending=0.
- en=0: cnt held at 0 with dir=up; pwm_hi, pwm_lo, pwm_synch forced 0 (registered). Shadow capture and pending still operate. Counting starts at cnt=0 on the cycle after en rises.
- Counter, edge mode: cnt increments 0..MAX and wraps; period 2^WIDTH cycles.
- Counter, centre mode: cnt counts up 0..MAX, then down MAX-1..1, then back to 0; period 2*MAX cycles. dir flips at cnt==MAX and at cnt==0.
- Boundary: cycle with en=1 and cnt==0 (in centre mode, the valley).
- pwm_synch: combinational, = en & (cnt==0 with dir=up).
- Shadow capture: duty_vld=1 captures duty into shadow (last write wins) and sets pending. Each channel is clamped to MAX-DEADTIME on capture.
- Active update: at a boundary with pending=1, active duty <= shadow, pending <= 0, duty_ack pulses for 1 cycle. duty_vld coincident with the boundary is captured and stays pending for the next boundary.
- Mode update: center_mode is latched into the active mode at every boundary. A mode change mid-period takes no effect until then.
- Outputs: registered, so each reflects the "next" value computed from cnt one cycle earlier. Widen intermediate sums to WIDTH+1 bits. d = active duty of the channel.
  - Edge mode: hi_next = (cnt >= DEADTIME) && (cnt < d); lo_next = (cnt >= d+DEADTIME) && (cnt != MAX).
  - Centre mode: hi_next = (cnt+DEADTIME < d); lo_next = (cnt >= d).
  - d=0: hi never asserts; lo has full width minus DEADTIME.
  - pwm_hi[k] and pwm_lo[k] must never be 1 together, in any mode or at any transition.
- Blanking: blank counter loads BLANK_WIDTH on any cycle in which any pwm_hi/pwm_lo bit rises; otherwise decrements toward 0. ovr_I_blank = (blank counter != 0). A retrigger mid-window reloads the count.
- Reset asserted mid-period: everything returns to reset values immediately (asynchronous).

Optional Feature:
Macro PWM_FAULT_EN adds input fault_n (1 bit, active-low).
- fault_n=0: a sticky fault flag sets. While the flag is set, pwm_hi and pwm_lo are forced 0 combinationally at the output, taking effect the same cycle.
- The flag clears only at a boundary where fault_n=1.
- Counter, handshake and pwm_synch are unaffected.
- Without the macro: no port, no flag, behaviour as above.

Test Plan:
- Defaults, edge mode, ch0 duty=1024 -> per 2048-cycle period: pwm_hi 960 cycles, pwm_lo 959 cycles, gaps >= 64 cycles each side, never overlapping.
- Centre mode, duty=512 -> period 4094 cycles; pwm_hi contiguous 895 cycles centred on the valley; pwm_lo 3071 cycles.
- duty_vld with duty=2047 mid-period -> no change until the next boundary; duty_ack pulses once at the boundary; active duty = 1983, so pwm_lo never asserts.
- duty_vld on the exact boundary cycle -> applied one period later; duty=0 -> pwm_hi stays 0.
- Two channel edges 50 cycles apart -> ovr_I_blank high continuously for 50+128 cycles after the first edge.
- Drop en, or (PWM_FAULT_EN) pulse fault_n low mid-period -> pwm_hi/pwm_lo low. For fault, outputs resume only after a boundary with fault_n=1.
